// File: rtl/conv_pkg.sv
// Shared constants and arithmetic helpers for the 3x3 convolution stage.
package conv_pkg;

   localparam int NTAP = 9;

   // Accumulator width: one PB+KB+1 product grows by 4 bits over nine taps.
   function automatic int acc_width(input int pb, input int kb);
      return pb + kb + 5;
   endfunction

   // Tap index inside the packed kernel; row 0 / col 0 is the oldest pixel.
   function automatic int tap_idx(input int row, input int col);
      return row * 3 + col;
   endfunction

   // Saturate a signed value into the unsigned pixel range [0, 2^pb-1].
   function automatic logic [31:0] clamp_pix(input logic signed [31:0] val,
                                             input int unsigned pb);
      logic signed [31:0] hi;
      hi = (32'sd1 <<< pb) - 32'sd1;
      if (val < 0)
         return '0;
      if (val > hi)
         return hi;
      return val;
   endfunction

endpackage

// File: rtl/conv_core_if.sv
// Pixel stream into the convolution stage and pixel push towards the output FIFO.
interface conv_core_if #(
   parameter int PB = 8
);
   logic [PB-1:0] px_in_data;
   logic          px_in_valid;
   logic          px_in_last_x;
   logic          px_in_last_y;
   logic          px_in_ready;
   logic          out_inf_busy;
   logic [PB-1:0] pix_data;
   logic          pix_en;

   // Environment side: pixel source upstream and output FIFO downstream.
   modport master (
      output px_in_data, px_in_valid, px_in_last_x, px_in_last_y, out_inf_busy,
      input  px_in_ready, pix_data, pix_en
   );

   // Convolution stage side.
   modport slave (
      input  px_in_data, px_in_valid, px_in_last_x, px_in_last_y, out_inf_busy,
      output px_in_ready, pix_data, pix_en
   );
endinterface

// File: rtl/line_buf.sv
// One raster line of pixels. The read port is combinational on addr so the
// word leaving the buffer can be forwarded during the same accept; the clock
// edge then overwrites that word, giving read-before-write behaviour.
module line_buf #(
   parameter int AB = 10,
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AB-1:0] addr,
   input  logic [DW-1:0] wdata,
   output logic [DW-1:0] rdata
);
   logic [DW-1:0] mem [2**AB];

   assign rdata = mem[addr];

   // Store the incoming word at the current column.
   always_ff @(posedge clk) begin
      if (we)
         mem[addr] <= wdata;
   end
endmodule

// File: rtl/conv_core.sv
// 3x3 convolution stage: two line buffers form the window, nine signed taps
// are summed, then shifted, clamped and pushed to the output interface.
// The whole pipeline freezes while the output FIFO reports busy.
module conv_core
   import conv_pkg::*;
#(
   parameter int XB = 10,
   parameter int YB = 10,
   parameter int PB = 8,
   parameter int KB = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [XB-1:0]      cfg_width,
   input  logic [YB-1:0]      cfg_height,
   input  logic [NTAP*KB-1:0] cfg_kernel,
   input  logic [3:0]         cfg_shift,
   conv_core_if.slave         bus,
   output logic               frame_done,
   output logic               frame_err
);
   localparam int AW = acc_width(PB, KB);
   localparam int MW = PB + KB + 1;

   logic                 adv;
   logic                 acc;
   logic [XB-1:0]        in_col;
   logic [YB-1:0]        in_row;
   logic                 col_end;
   logic                 row_end;
   logic [PB-1:0]        lb0_rd;
   logic [PB-1:0]        lb1_rd;
   logic [PB-1:0]        win [3][3];
   logic                 win_valid;
   logic                 win_last;
   logic signed [PB:0]   tap_px;
   logic signed [KB-1:0] tap_k;
   logic signed [MW-1:0] tap_prod;
   logic signed [AW-1:0] sum_comb;
   logic signed [AW-1:0] s1_sum;
   logic signed [AW-1:0] shifted;
   logic                 s1_valid;
   logic                 s1_last;
   logic [PB-1:0]        pix_next;
   logic [PB-1:0]        pix_q;
   logic                 s2_valid;
   logic                 s2_last;

   assign adv             = ~bus.out_inf_busy;
   assign bus.px_in_ready = ~bus.out_inf_busy & ~rst;
   assign acc             = bus.px_in_valid & bus.px_in_ready;
   assign col_end         = (in_col == cfg_width);
   assign row_end         = (in_row == cfg_height);

   // LB0 holds row r-1; LB1 receives what LB0 held, so it lags by one more row.
   line_buf #(.AB(XB), .DW(PB)) u_lb0 (
      .clk   (clk),
      .we    (acc),
      .addr  (in_col),
      .wdata (bus.px_in_data),
      .rdata (lb0_rd)
   );

   line_buf #(.AB(XB), .DW(PB)) u_lb1 (
      .clk   (clk),
      .we    (acc),
      .addr  (in_col),
      .wdata (lb0_rd),
      .rdata (lb1_rd)
   );

   // Raster position and sticky framing check; the counters never resync to markers.
   always_ff @(posedge clk) begin
      if (rst) begin
         in_col    <= '0;
         in_row    <= '0;
         frame_err <= 1'b0;
      end else if (acc) begin
         if (col_end) begin
            in_col <= '0;
            in_row <= row_end ? '0 : in_row + 1'b1;
         end else begin
            in_col <= in_col + 1'b1;
         end
         if ((bus.px_in_last_x != col_end) ||
             (bus.px_in_last_x && (bus.px_in_last_y != row_end)))
            frame_err <= 1'b1;
      end
   end

   // Window shift: columns move left, the new column {r-2, r-1, r} enters right.
   always_ff @(posedge clk) begin
      if (acc) begin
         for (int r = 0; r < 3; r++) begin
            win[r][0] <= win[r][1];
            win[r][1] <= win[r][2];
         end
         win[0][2] <= lb1_rd;
         win[1][2] <= lb0_rd;
         win[2][2] <= bus.px_in_data;
      end
   end

   // Nine zero-extended pixels times signed coefficients, summed at full width.
   always_comb begin
      sum_comb = '0;
      tap_px   = '0;
      tap_k    = '0;
      tap_prod = '0;
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 3; c++) begin
            tap_px   = {1'b0, win[r][c]};
            tap_k    = cfg_kernel[tap_idx(r, c)*KB +: KB];
            tap_prod = MW'(tap_px) * MW'(tap_k);
            sum_comb = sum_comb + AW'(tap_prod);
         end
      end
   end

   // Arithmetic shift floors toward -inf before saturation.
   always_comb begin
      shifted  = s1_sum >>> cfg_shift;
      pix_next = PB'(clamp_pix(32'(shifted), PB));
   end

   // Valid/last tokens and data move one stage per unstalled cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         win_valid <= 1'b0;
         win_last  <= 1'b0;
         s1_valid  <= 1'b0;
         s1_last   <= 1'b0;
         s1_sum    <= '0;
         s2_valid  <= 1'b0;
         s2_last   <= 1'b0;
         pix_q     <= '0;
      end else if (adv) begin
         win_valid <= acc && (in_row >= YB'(2)) && (in_col >= XB'(2));
         win_last  <= acc && row_end && col_end;
         s1_valid  <= win_valid;
         s1_last   <= win_last;
         if (win_valid)
            s1_sum <= sum_comb;
         s2_valid  <= s1_valid;
         s2_last   <= s1_last;
         if (s1_valid)
            pix_q <= pix_next;
      end
   end

   assign bus.pix_data = pix_q;
   assign bus.pix_en   = s2_valid & adv;
   assign frame_done   = s2_valid & s2_last & adv;

endmodule

// File: tb/tb_conv_core.sv
// Directed bench for conv_core: reset, kernels, clamp, stall, framing, reset mid-frame.
module tb_conv_core;
   localparam int XB = 10;
   localparam int YB = 10;
   localparam int PB = 8;
   localparam int KB = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [XB-1:0] cfg_width;
   logic [YB-1:0] cfg_height;
   logic [9*KB-1:0] cfg_kernel;
   logic [3:0]    cfg_shift;
   logic          frame_done;
   logic          frame_err;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int kern [9];
   int shift_v;
   int acc_cyc_mark;
   int err_acc_cyc;
   int err_cyc;
   int got_q  [$];
   int done_q [$];
   int cyc_q  [$];
   int exp_q  [$];

   conv_core_if #(.PB(PB)) bus ();

   conv_core #(.XB(XB), .YB(YB), .PB(PB), .KB(KB)) dut (
      .clk        (clk),
      .rst        (rst),
      .cfg_width  (cfg_width),
      .cfg_height (cfg_height),
      .cfg_kernel (cfg_kernel),
      .cfg_shift  (cfg_shift),
      .bus        (bus),
      .frame_done (frame_done),
      .frame_err  (frame_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Collect pushed pixels; while busy, nothing may be pushed or accepted.
   always @(negedge clk) begin
      if (bus.pix_en === 1'b1) begin
         got_q.push_back(int'(bus.pix_data));
         done_q.push_back(int'(frame_done));
         cyc_q.push_back(cyc);
      end
      if (bus.out_inf_busy === 1'b1) begin
         checks++;
         if (bus.pix_en !== 1'b0 || bus.px_in_ready !== 1'b0) begin
            errors++;
            $display("FAIL busy_gate: pix_en=%0b px_in_ready=%0b, required 0 and 0",
                     bus.pix_en, bus.px_in_ready);
         end
      end
   end

   // First cycle in which frame_err reads high.
   always @(posedge clk) begin
      #1;
      if (frame_err === 1'b1 && err_cyc < 0)
         err_cyc = cyc;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic int pix_val(input int mode, input int r, input int c, input int w);
      case (mode)
         0:       return (r * w + c) & 255;
         1:       return 255;
         2:       return (r * 37 + c * 11 + 3) & 255;
         default: return (100 + r * w + c) & 255;
      endcase
   endfunction

   task automatic load_cfg(input int w, input int h, input int sh);
      cfg_width  = XB'(w - 1);
      cfg_height = YB'(h - 1);
      cfg_shift  = 4'(sh);
      shift_v    = sh;
      for (int k = 0; k < 9; k++)
         cfg_kernel[k*KB +: KB] = KB'(kern[k]);
   endtask

   task automatic set_kern(input int k0, input int k1, input int k2, input int k3,
                           input int k4, input int k5, input int k6, input int k7,
                           input int k8);
      kern = '{k0, k1, k2, k3, k4, k5, k6, k7, k8};
   endtask

   task automatic clear_q();
      got_q.delete();
      done_q.delete();
      cyc_q.delete();
   endtask

   // Reference: output for input (r,c) uses rows r-2..r and columns c-2..c.
   task automatic build_expected(input int w, input int h, input int mode);
      int s;
      exp_q.delete();
      for (int r = 2; r < h; r++) begin
         for (int c = 2; c < w; c++) begin
            s = 0;
            for (int i = 0; i < 3; i++)
               for (int j = 0; j < 3; j++)
                  s += kern[i*3+j] * pix_val(mode, r - 2 + i, c - 2 + j, w);
            s = s >>> shift_v;
            if (s < 0) s = 0;
            if (s > 255) s = 255;
            exp_q.push_back(s);
         end
      end
   endtask

   task automatic send_frame(input int w, input int h, input int mode, input bit rnd_busy,
                             input int err_col, input int stop_r, input int stop_c);
      for (int r = 0; r < h; r++) begin
         for (int c = 0; c < w; c++) begin
            int tries;
            bit b;
            bus.px_in_valid  = 1'b1;
            bus.px_in_data   = PB'(pix_val(mode, r, c, w));
            bus.px_in_last_x = (c == w - 1) || (r == 0 && c == err_col);
            bus.px_in_last_y = (r == h - 1);
            tries = 0;
            do begin
               b = rnd_busy ? bit'($urandom_range(0, 1)) : 1'b0;
               bus.out_inf_busy = b;
               @(posedge clk);
               #1;
               tries++;
            end while (b && tries < 1000);
            if (b) begin
               checks++;
               errors++;
               $display("FAIL accept_timeout: pixel (%0d,%0d) not accepted in %0d cycles", r, c, tries);
            end
            if (r == 2 && c == 2) acc_cyc_mark = cyc;
            if (r == 0 && c == err_col) err_acc_cyc = cyc;
            if (r == stop_r && c == stop_c) begin
               bus.px_in_valid  = 1'b0;
               bus.out_inf_busy = 1'b0;
               return;
            end
         end
      end
      bus.px_in_valid  = 1'b0;
      bus.out_inf_busy = 1'b0;
      bus.px_in_last_x = 1'b0;
      bus.px_in_last_y = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks += 5;
      if (bus.pix_en !== 1'b0) begin errors++; $display("FAIL reset_pix_en: got %0b, required 0", bus.pix_en); end
      if (bus.pix_data !== 8'd0) begin errors++; $display("FAIL reset_pix_data: got %0d, required 0", bus.pix_data); end
      if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %0b, required 0", frame_done); end
      if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %0b, required 0", frame_err); end
      if (bus.px_in_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %0b, required 0", bus.px_in_ready); end
      rst = 1'b0;
      idle(1);
   endtask

   task automatic test_identity();
      int ev [4];
      int dv [4];
      ev = '{5, 6, 9, 10};
      dv = '{0, 0, 0, 1};
      set_kern(0, 0, 0, 0, 1, 0, 0, 0, 0);
      load_cfg(4, 4, 0);
      clear_q();
      send_frame(4, 4, 0, 1'b0, -1, -1, -1);
      idle(6);
      checks++;
      if (got_q.size() != 4) begin errors++; $display("FAIL identity_count: got %0d outputs, required 4", got_q.size()); end
      for (int i = 0; i < 4 && i < got_q.size(); i++) begin
         checks += 2;
         if (got_q[i] != ev[i]) begin errors++; $display("FAIL identity_data[%0d]: got %0d, required %0d", i, got_q[i], ev[i]); end
         if (done_q[i] != dv[i]) begin errors++; $display("FAIL identity_done[%0d]: got %0d, required %0d", i, done_q[i], dv[i]); end
      end
      if (got_q.size() >= 2) begin
         checks += 2;
         if (cyc_q[0] != acc_cyc_mark + 2) begin errors++; $display("FAIL identity_latency: first pix_en at cycle %0d, required %0d", cyc_q[0], acc_cyc_mark + 2); end
         if (cyc_q[1] != cyc_q[0] + 1) begin errors++; $display("FAIL identity_back_to_back: second pix_en at cycle %0d, required %0d", cyc_q[1], cyc_q[0] + 1); end
      end
   endtask

   task automatic test_box();
      int ev [4];
      ev = '{5, 6, 10, 11};
      set_kern(1, 1, 1, 1, 1, 1, 1, 1, 1);
      load_cfg(4, 4, 3);
      clear_q();
      send_frame(4, 4, 0, 1'b0, -1, -1, -1);
      idle(6);
      checks++;
      if (got_q.size() != 4) begin errors++; $display("FAIL box_count: got %0d outputs, required 4", got_q.size()); end
      for (int i = 0; i < 4 && i < got_q.size(); i++) begin
         checks++;
         if (got_q[i] != ev[i]) begin errors++; $display("FAIL box_data[%0d]: got %0d, required %0d", i, got_q[i], ev[i]); end
      end
      if (got_q.size() == 4) begin
         checks++;
         if (done_q[3] != 1) begin errors++; $display("FAIL box_done: got %0d, required 1", done_q[3]); end
      end
   endtask

   task automatic test_clamp();
      set_kern(0, 0, 0, 0, -1, 0, 0, 0, 0);
      load_cfg(4, 4, 0);
      clear_q();
      send_frame(4, 4, 1, 1'b0, -1, -1, -1);
      idle(6);
      checks++;
      if (got_q.size() != 4) begin errors++; $display("FAIL clamp_low_count: got %0d outputs, required 4", got_q.size()); end
      for (int i = 0; i < got_q.size(); i++) begin
         checks++;
         if (got_q[i] != 0) begin errors++; $display("FAIL clamp_low[%0d]: got %0d, required 0", i, got_q[i]); end
      end
      set_kern(1, 1, 1, 1, 1, 1, 1, 1, 1);
      load_cfg(4, 4, 0);
      clear_q();
      send_frame(4, 4, 1, 1'b0, -1, -1, -1);
      idle(6);
      checks++;
      if (got_q.size() != 4) begin errors++; $display("FAIL clamp_high_count: got %0d outputs, required 4", got_q.size()); end
      for (int i = 0; i < got_q.size(); i++) begin
         checks++;
         if (got_q[i] != 255) begin errors++; $display("FAIL clamp_high[%0d]: got %0d, required 255", i, got_q[i]); end
      end
   endtask

   task automatic test_back_to_back();
      int ev [8];
      int dv [8];
      ev = '{5, 6, 9, 10, 5, 6, 9, 10};
      dv = '{0, 0, 0, 1, 0, 0, 0, 1};
      set_kern(0, 0, 0, 0, 1, 0, 0, 0, 0);
      load_cfg(4, 4, 0);
      clear_q();
      send_frame(4, 4, 0, 1'b0, -1, -1, -1);
      send_frame(4, 4, 0, 1'b0, -1, -1, -1);
      idle(6);
      checks++;
      if (got_q.size() != 8) begin errors++; $display("FAIL b2b_count: got %0d outputs, required 8", got_q.size()); end
      for (int i = 0; i < 8 && i < got_q.size(); i++) begin
         checks += 2;
         if (got_q[i] != ev[i]) begin errors++; $display("FAIL b2b_data[%0d]: got %0d, required %0d", i, got_q[i], ev[i]); end
         if (done_q[i] != dv[i]) begin errors++; $display("FAIL b2b_done[%0d]: got %0d, required %0d", i, done_q[i], dv[i]); end
      end
   endtask

   task automatic test_random_busy();
      set_kern(-1, 2, -1, 3, 4, -2, 1, -3, 5);
      load_cfg(16, 8, 1);
      build_expected(16, 8, 2);
      clear_q();
      send_frame(16, 8, 2, 1'b1, -1, -1, -1);
      idle(6);
      checks++;
      if (got_q.size() != 84) begin errors++; $display("FAIL busy_count: got %0d outputs, required 84", got_q.size()); end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         checks++;
         if (got_q[i] != exp_q[i]) begin errors++; $display("FAIL busy_data[%0d]: got %0d, required %0d", i, got_q[i], exp_q[i]); end
      end
      if (got_q.size() == 84) begin
         checks++;
         if (done_q[83] != 1) begin errors++; $display("FAIL busy_done: got %0d, required 1", done_q[83]); end
      end
   endtask

   task automatic test_reset_mid();
      int ev [4];
      ev = '{5, 6, 9, 10};
      set_kern(0, 0, 0, 0, 1, 0, 0, 0, 0);
      load_cfg(4, 4, 0);
      send_frame(4, 4, 3, 1'b0, -1, 3, 2);
      rst = 1'b1;
      clear_q();
      idle(1);
      checks++;
      if (bus.px_in_ready !== 1'b0) begin errors++; $display("FAIL rst_mid_ready: got %0b, required 0", bus.px_in_ready); end
      idle(1);
      rst = 1'b0;
      idle(1);
      send_frame(4, 4, 0, 1'b0, -1, -1, -1);
      idle(6);
      checks++;
      if (got_q.size() != 4) begin errors++; $display("FAIL rst_mid_count: got %0d outputs, required 4", got_q.size()); end
      for (int i = 0; i < 4 && i < got_q.size(); i++) begin
         checks++;
         if (got_q[i] != ev[i]) begin errors++; $display("FAIL rst_mid_data[%0d]: got %0d, required %0d", i, got_q[i], ev[i]); end
      end
   endtask

   task automatic test_frame_err();
      int ev [4];
      ev = '{5, 6, 9, 10};
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
      err_cyc = -1;
      err_acc_cyc = -2;
      set_kern(0, 0, 0, 0, 1, 0, 0, 0, 0);
      load_cfg(4, 4, 0);
      clear_q();
      send_frame(4, 4, 0, 1'b0, 2, -1, -1);
      idle(6);
      checks += 2;
      if (err_cyc != err_acc_cyc) begin errors++; $display("FAIL err_rise: first high at cycle %0d, required %0d", err_cyc, err_acc_cyc); end
      if (frame_err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %0b, required 1", frame_err); end
      checks++;
      if (got_q.size() != 4) begin errors++; $display("FAIL err_count: got %0d outputs, required 4", got_q.size()); end
      for (int i = 0; i < 4 && i < got_q.size(); i++) begin
         checks++;
         if (got_q[i] != ev[i]) begin errors++; $display("FAIL err_data[%0d]: got %0d, required %0d", i, got_q[i], ev[i]); end
      end
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
      checks++;
      if (frame_err !== 1'b0) begin errors++; $display("FAIL err_clear: got %0b, required 0", frame_err); end
   endtask

   initial begin
      bus.px_in_valid  = 1'b0;
      bus.px_in_data   = '0;
      bus.px_in_last_x = 1'b0;
      bus.px_in_last_y = 1'b0;
      bus.out_inf_busy = 1'b0;
      err_cyc          = -1;
      err_acc_cyc      = -2;
      acc_cyc_mark     = 0;
      set_kern(0, 0, 0, 0, 1, 0, 0, 0, 0);
      load_cfg(4, 4, 0);
      test_reset();
      test_identity();
      test_box();
      test_clamp();
      test_back_to_back();
      test_random_busy();
      test_reset_mid();
      test_frame_err();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
